pixel_scanner: RTL and testbench

PIXEL_SCANNER -- requirements
Module: pixel_scanner

---
 rtl/pixel_scanner.sv | 109 ++++++++++
 tb/tb_pixel_scanner.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scanner.sv
// Raster scan coordinate generator: walks (x, y) over a PIXEL_W x PIXEL_H frame,
// honouring downstream stall, with optional back-to-back continuous frames.
module pixel_scanner #(
    parameter int unsigned PIXEL_W = 800,
    parameter int unsigned PIXEL_H = 600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    input  logic       stall,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pixel_valid,
    output logic       first_pixel,
    output logic       last_pixel,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_count
);

    localparam logic [9:0] XLast = 10'(PIXEL_W - 1);
    localparam logic [9:0] YLast = 10'(PIXEL_H - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic [7:0] count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    x_d     = '0;
                    y_d     = '0;
                    valid_d = 1'b1;
                end
            end
            StScan: begin
                // A stalled cycle leaves every register untouched so no coordinate is lost.
                if (!stall) begin
                    if (x_q != XLast) begin
                        x_d = x_q + 10'd1;
                    end else if (y_q != YLast) begin
                        x_d = '0;
                        y_d = y_q + 10'd1;
                    end else begin
                        state_d = StDone;
                        x_d     = '0;
                        y_d     = '0;
                        valid_d = 1'b0;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            StDone: begin
                // Coordinates are already back at (0,0), so a continuous restart only re-arms valid.
                if (continuous) begin
                    state_d = StScan;
                    valid_d = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign pixel_valid = valid_q;
    assign first_pixel = valid_q && (x_q == 10'd0) && (y_q == 10'd0);
    assign last_pixel  = valid_q && (x_q == XLast) && (y_q == YLast);
    assign busy        = (state_q != StIdle);
    assign frame_done  = (state_q == StDone);
    assign frame_count = count_q;

endmodule

// File: tb/tb_pixel_scanner.sv
// Scoreboard bench for pixel_scanner: expected coordinates are queued when a frame is
// requested and popped as the DUT consumes them.
module tb_pixel_scanner;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       f;
        logic       l;
    } coord_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic       stall = 1'b0;
    logic [9:0] px, py;
    logic       pv, fp, lp, busy, fd;
    logic [7:0] fc;

    logic       rst_n_b = 1'b0;
    logic       start_b = 1'b0;
    logic [9:0] bx, by;
    logic       bv, bf, bl, bb, bd;
    logic [7:0] bc;

    int         n_cmp = 0;
    int         n_bad = 0;
    coord_t     exp_q[$];
    logic [7:0] exp_fc = 8'd0;

    always #5 clk = ~clk;

    pixel_scanner #(.PIXEL_W(W), .PIXEL_H(H)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .stall(stall),
        .pixel_x(px), .pixel_y(py), .pixel_valid(pv), .first_pixel(fp), .last_pixel(lp),
        .busy(busy), .frame_done(fd), .frame_count(fc)
    );

    pixel_scanner u_big (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .continuous(1'b0), .stall(1'b0),
        .pixel_x(bx), .pixel_y(by), .pixel_valid(bv), .first_pixel(bf), .last_pixel(bl),
        .busy(bb), .frame_done(bd), .frame_count(bc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        coord_t c;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                c.x = 10'(x);
                c.y = 10'(y);
                c.f = (x == 0 && y == 0);
                c.l = (x == W - 1 && y == H - 1);
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic test_reset();
        logic [32:0] outs;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outs = {px, py, pv, fp, lp, busy, fd, fc};
        n_cmp++;
        if (outs !== 33'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        step();
        step();
        n_cmp++;
        if ({pv, busy, fd} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_no_start: got %b expected 000", {pv, busy, fd});
        end
    endtask

    task automatic test_single_frame();
        int nvalid;
        bit done;
        nvalid = 0;
        done = 0;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pv) begin
                nvalid++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL single_extra: got (%0d,%0d) expected none", px, py);
                end else begin
                    if ({px, py, fp, lp} !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL single_coord: got %h expected %h",
                                 {px, py, fp, lp}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (fd) begin
                done = 1;
                break;
            end
            step();
        end
        exp_fc = exp_fc + 8'd1;
        n_cmp++;
        if (!done || nvalid != 12 || fc !== exp_fc || pv !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_done: got done=%0d valid=%0d count=%0d pv=%b busy=%b expected 1 12 %0d 0 1",
                     done, nvalid, fc, pv, busy, exp_fc);
        end
        step();
        n_cmp++;
        if ({busy, fd, pv} !== 3'b000) begin
            n_bad++;
            $display("FAIL single_idle: got %b expected 000", {busy, fd, pv});
        end
    endtask

    task automatic test_stall();
        int nvalid;
        int hold;
        int n30;
        bit done;
        nvalid = 0;
        hold = 0;
        n30 = 0;
        done = 0;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pv) begin
                nvalid++;
                if (px == 10'd3 && py == 10'd0) n30++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_extra: got (%0d,%0d) expected none", px, py);
                end else if ({px, py, fp, lp} !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL stall_coord: got %h expected %h", {px, py, fp, lp}, exp_q[0]);
                end
                if (px == 10'd3 && py == 10'd0 && hold < 3) begin
                    stall = 1'b1;
                    hold++;
                end else begin
                    stall = 1'b0;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
            if (fd) begin
                done = 1;
                stall = 1'b1;
                break;
            end
            step();
        end
        exp_fc = exp_fc + 8'd1;
        n_cmp++;
        if (!done || nvalid != 15 || n30 != 4 || fc !== exp_fc) begin
            n_bad++;
            $display("FAIL stall_frame: got done=%0d valid=%0d held=%0d count=%0d expected 1 15 4 %0d",
                     done, nvalid, n30, fc, exp_fc);
        end
        step();
        stall = 1'b0;
        n_cmp++;
        if ({busy, fd} !== 2'b00) begin
            n_bad++;
            $display("FAIL stall_done_len: got %b expected 00", {busy, fd});
        end
    endtask

    task automatic test_continuous();
        int nfd;
        int first_fd;
        int gap;
        bit prev_fd;
        nfd = 0;
        first_fd = 0;
        gap = 0;
        prev_fd = 0;
        continuous = 1'b1;
        push_frame();
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (prev_fd) begin
                n_cmp++;
                if ({pv, px, py, fp} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
                    n_bad++;
                    $display("FAIL cont_restart: got v=%b (%0d,%0d) expected v=1 (0,0)", pv, px, py);
                end
            end
            prev_fd = 0;
            if (pv) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL cont_extra: got (%0d,%0d) expected none", px, py);
                end else begin
                    if ({px, py, fp, lp} !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL cont_coord: got %h expected %h",
                                 {px, py, fp, lp}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (fd) begin
                nfd++;
                prev_fd = 1;
                if (nfd == 1) begin
                    first_fd = i;
                end else begin
                    gap = i - first_fd;
                    continuous = 1'b0;
                    break;
                end
            end
            step();
        end
        exp_fc = exp_fc + 8'd2;
        n_cmp++;
        if (nfd != 2 || gap != 13 || fc !== exp_fc || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL cont_frames: got fd=%0d gap=%0d count=%0d left=%0d expected 2 13 %0d 0",
                     nfd, gap, fc, exp_q.size(), exp_fc);
        end
        continuous = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_start_held();
        int nvalid;
        int nfd;
        nvalid = 0;
        nfd = 0;
        push_frame();
        start = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            if (pv) begin
                nvalid++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL held_extra: got (%0d,%0d) expected none", px, py);
                end else begin
                    if ({px, py, fp, lp} !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL held_coord: got %h expected %h",
                                 {px, py, fp, lp}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (fd) begin
                nfd++;
                break;
            end
            step();
        end
        exp_fc = exp_fc + 8'd1;
        step();
        start = 1'b0;
        n_cmp++;
        if (nfd != 1 || nvalid != 12 || fc !== exp_fc || busy !== 1'b0 || pv !== 1'b0) begin
            n_bad++;
            $display("FAIL held_frame: got fd=%0d valid=%0d count=%0d busy=%b pv=%b expected 1 12 %0d 0 0",
                     nfd, nvalid, fc, busy, pv, exp_fc);
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] outs;
        int nfd;
        int nact;
        bit done;
        nfd = 0;
        nact = 0;
        done = 0;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pv && px == 10'd2 && py == 10'd1) break;
            step();
        end
        n_cmp++;
        if ({pv, px, py} !== {1'b1, 10'd2, 10'd1}) begin
            n_bad++;
            $display("FAIL mid_reach: got v=%b (%0d,%0d) expected v=1 (2,1)", pv, px, py);
        end
        #2;
        rst_n = 1'b0;
        #1;
        outs = {px, py, pv, fp, lp, busy, fd, fc};
        n_cmp++;
        if (outs !== 33'd0) begin
            n_bad++;
            $display("FAIL mid_async_reset: got %h expected 0", outs);
        end
        exp_q.delete();
        exp_fc = 8'd0;
        step();
        step();
        rst_n = 1'b1;
        repeat (20) begin
            step();
            if (fd) nfd++;
            if (pv || busy) nact++;
        end
        n_cmp++;
        if (nfd != 0 || nact != 0 || fc !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_after_release: got fd=%0d active=%0d count=%0d expected 0 0 0",
                     nfd, nact, fc);
        end
        // Release reset with start already high: the very next edge must launch a frame.
        rst_n = 1'b0;
        step();
        start = 1'b1;
        rst_n = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if ({pv, px, py, fp} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_restart: got v=%b (%0d,%0d) f=%b expected v=1 (0,0) f=1",
                     pv, px, py, fp);
        end
        for (int i = 0; i < 20; i++) begin
            if (fd) begin
                done = 1;
                break;
            end
            step();
        end
        exp_fc = exp_fc + 8'd1;
        n_cmp++;
        if (!done || fc !== exp_fc) begin
            n_bad++;
            $display("FAIL mid_refinish: got done=%0d count=%0d expected 1 %0d", done, fc, exp_fc);
        end
        step();
    endtask

    task automatic test_count_wrap();
        int nfd;
        nfd = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_fc = 8'd0;
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 256 * 13 + 40; i++) begin
            if (fd) begin
                nfd++;
                exp_fc = exp_fc + 8'd1;
                n_cmp++;
                if (fc !== exp_fc) begin
                    n_bad++;
                    $display("FAIL wrap_count: got %0d expected %0d", fc, exp_fc);
                end
                if (nfd == 256) begin
                    continuous = 1'b0;
                    break;
                end
            end
            step();
        end
        n_cmp++;
        if (nfd != 256 || fc !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_total: got fd=%0d count=%0d expected 256 0", nfd, fc);
        end
        continuous = 1'b0;
        step();
    endtask

    task automatic test_default_size();
        rst_n_b = 1'b1;
        step();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i <= 800; i++) begin
            if (i == 0) begin
                n_cmp++;
                if ({bv, bx, by, bf, bl} !== {1'b1, 10'd0, 10'd0, 1'b1, 1'b0}) begin
                    n_bad++;
                    $display("FAIL big_first: got v=%b (%0d,%0d) f=%b l=%b expected v=1 (0,0) f=1 l=0",
                             bv, bx, by, bf, bl);
                end
            end
            if (i == 799) begin
                n_cmp++;
                if ({bv, bx, by, bl} !== {1'b1, 10'd799, 10'd0, 1'b0}) begin
                    n_bad++;
                    $display("FAIL big_line_end: got v=%b (%0d,%0d) l=%b expected v=1 (799,0) l=0",
                             bv, bx, by, bl);
                end
            end
            if (i == 800) begin
                n_cmp++;
                if ({bv, bx, by, bb, bd, bc} !== {1'b1, 10'd0, 10'd1, 1'b1, 1'b0, 8'd0}) begin
                    n_bad++;
                    $display("FAIL big_wrap: got v=%b (%0d,%0d) busy=%b fd=%b cnt=%0d expected v=1 (0,1) 1 0 0",
                             bv, bx, by, bb, bd, bc);
                end
                break;
            end
            step();
        end
        rst_n_b = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_continuous();
        test_start_held();
        test_reset_mid();
        test_count_wrap();
        test_default_size();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
